rf_wb_ctrl: RTL and testbench
=============================

// Module: rf_wb_ctrl
// PURPOSE
//  Writer side of the register-file write port: drives wen/waddr/wdata into RF.
//  Merges the in-order pipeline writeback with results from a multi-cycle unit
//  (load/div) buffered in a small FIFO; pipeline has priority, FIFO drains in idle slots.
//  Starvation counter requests a one-cycle pipeline bubble so buffered results retire.
// PARAMETERS
//  ADDR_WIDTH   5   register index width
//  DATAWIDTH    32  register data width
//  FIFO_DEPTH   4   multi-cycle result buffer entries (power of 2, >=2)
//  STARVE_MAX   8   consecutive blocked cycles before stall_req asserts
// PORTS
//  clk         in   1           clock, all state on posedge
//  rst_n       in   1           asynchronous reset, active-low
//  pipe_valid  in   1           pipeline writeback valid (no backpressure)
//  pipe_rd     in   ADDR_WIDTH  pipeline destination register
//  pipe_data   in   DATAWIDTH   pipeline result
//  mc_valid    in   1           multi-cycle result valid
//  mc_ready    out  1           FIFO can accept (= !full)
//  mc_rd       in   ADDR_WIDTH  multi-cycle destination register
//  mc_data     in   DATAWIDTH   multi-cycle result
//  wen         out  1           RF write enable (registered)
//  waddr       out  ADDR_WIDTH  RF write address (registered)
//  wdata       out  DATAWIDTH   RF write data (registered)
//  stall_req   out  1           request pipeline hold pipe_valid low next cycle
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently buffered
// BEHAVIOUR
//  - Reset (rst_n=0, async): wen=0, waddr=0, wdata=0, stall_req=0, FIFO empty,
//    fifo_level=0, mc_ready=1 once reset released; starve count=0.
//  - Pipe path: pipe_valid=1 & pipe_rd!=0 at edge N -> wen=1,waddr/wdata at N+1.
//  - x0: pipe_rd==0 gives no write; mc handshake with mc_rd==0 completes, entry dropped.
//  - MC accept: mc_valid & mc_ready at edge N -> enqueued; level updates at N+1.
//  - Drain: when !pipe_valid (or pipe_rd==0) and FIFO non-empty, pop head -> wen at N+1.
//    Earliest mc-to-wen latency 2 cycles (enqueue N, pop N+1, wen N+2).
//  - mc_ready = (level < FIFO_DEPTH), from registered level; no same-cycle
//    pass-through when full even if a pop occurs that cycle.
//  - Simultaneous push+pop when not full: both happen, level unchanged.
//  - Pointers wrap modulo FIFO_DEPTH; level counts 0..FIFO_DEPTH exactly.
//  - Starve counter: +1 each cycle FIFO non-empty and pipe write blocks drain;
//    cleared on any pop or when FIFO empty; saturates at STARVE_MAX.
//    stall_req = (count==STARVE_MAX), registered. If pipe still valid, pipe wins.
//  - Ordering: FIFO entries retire in arrival order; if pipe and FIFO head target
//    same rd, pipe writes first, FIFO write lands later (program order is the
//    multi-cycle unit's responsibility).
//  - wen deasserts the cycle after no source selected; waddr/wdata hold last value.
// CONFIGURATION
//  RF_WB_PENDING_EN defined: extra output pending [2**ADDR_WIDTH-1:0]; bit r set
//    while any FIFO entry targets r (for hazard detection); bit 0 always 0;
//    updated the cycle after push/pop. Undefined: port and logic absent.
// STRUCTURE
//  rf_wb_pkg: typedef struct packed wb_req_t {rd, data}; localparams for widths;
//    function is_x0(). Sub-module rf_wb_fifo (sync FIFO of wb_req_t, DEPTH param,
//    push/pop/full/empty/level); arbitration, starve counter, output regs in top.
// TESTING
//  1 reset mid-drain: level=3, pull rst_n low -> wen=0,level=0,stall_req=0 same cycle.
//  2 pipe only: pipe_rd=5,data=0xDEADBEEF -> next cycle wen=1,waddr=5,wdata=0xDEADBEEF;
//    pipe_rd=0 -> wen=0.
//  3 mc fill: 5 pushes, pipe busy -> 4 accepted, mc_ready=0 after 4th, level=4.
//  4 drain: idle pipe, rd 1..4 buffered -> wen writes 1,2,3,4 back-to-back in order.
//  5 starvation: 1 entry, pipe valid 8 cycles -> stall_req=1; drop pipe_valid ->
//    entry written next cycle, stall_req clears.
//  6 mc_rd=0 accepted -> level stays 0, no wen; with RF_WB_PENDING_EN, rd=7 push ->
//    pending[7]=1 until popped.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file writeback controller.
// Latency: n/a (types and helpers only). Backpressure: n/a.
// The RF_WB_PENDING_EN option is handled in rf_wb_fifo and rf_wb_ctrl.
package rf_wb_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] rd;
        logic [RF_DATA_W-1:0] data;
    } wb_req_t;

    // Register 0 is hardwired; writes to it are discarded.
    function automatic logic is_x0(input logic [RF_ADDR_W-1:0] rd);
        return rd == '0;
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of wb_req_t with occupancy level; option RF_WB_PENDING_EN exports slots.
// Latency: push visible at head one cycle later; level updates the cycle after push/pop.
// Backpressure: push ignored when full, pop ignored when empty.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  wb_req_t               push_dat,
    input  logic                  pop,
    output wb_req_t               head_dat,
    output logic                  full,
    output logic                  empty,
`ifdef RF_WB_PENDING_EN
    output wb_req_t [DEPTH-1:0]   slot_dat,
    output logic    [DEPTH-1:0]   slot_vld,
`endif
    output logic [$clog2(DEPTH):0] level
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] LVL_ONE = 1;

    wb_req_t [DEPTH-1:0] mem_q;
    logic [PW-1:0]       wr_ptr_q;
    logic [PW-1:0]       rd_ptr_q;
    logic [PW:0]         level_q;
    logic                push_ok;
    logic                pop_ok;

    assign full     = (level_q == DEPTH[PW:0]);
    assign empty    = (level_q == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign head_dat = mem_q[rd_ptr_q];
    assign level    = level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset: slots are only read while counted in level.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat;
    end

`ifdef RF_WB_PENDING_EN
    assign slot_dat = mem_q;

    always_comb begin
        slot_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_vld[i] = ({1'b0, PW'(PW'(i) - rd_ptr_q)} < level_q);
        end
    end
`endif

endmodule

// File: rtl/rf_wb_ctrl.sv
// RF write-port arbiter: pipeline writeback wins, buffered multi-cycle results drain in idle slots.
// Latency: pipe -> wen 1 cycle; mc -> wen >= 2 cycles. Option RF_WB_PENDING_EN adds pending[].
// Backpressure: none on pipe; mc_ready = !full from registered level; stall_req after starvation.
module rf_wb_ctrl
    import rf_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_W,
    parameter int DATAWIDTH  = RF_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pipe_valid,
    input  logic [ADDR_WIDTH-1:0]         pipe_rd,
    input  logic [DATAWIDTH-1:0]          pipe_data,
    input  logic                          mc_valid,
    output logic                          mc_ready,
    input  logic [ADDR_WIDTH-1:0]         mc_rd,
    input  logic [DATAWIDTH-1:0]          mc_data,
    output logic                          wen,
    output logic [ADDR_WIDTH-1:0]         waddr,
    output logic [DATAWIDTH-1:0]          wdata,
    output logic                          stall_req,
`ifdef RF_WB_PENDING_EN
    output logic [2**ADDR_WIDTH-1:0]      pending,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic                  pipe_wr;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    wb_req_t               head;

    logic                  wen_q,   wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATAWIDTH-1:0]  wdata_q, wdata_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  stall_q, stall_d;

`ifdef RF_WB_PENDING_EN
    wb_req_t [FIFO_DEPTH-1:0] slot_dat;
    logic    [FIFO_DEPTH-1:0] slot_vld;
`endif

    assign pipe_wr  = pipe_valid && !is_x0(pipe_rd);
    assign mc_ready = !full;
    // An accepted x0 result completes its handshake but never occupies a slot.
    assign push     = mc_valid && mc_ready && !is_x0(mc_rd);
    assign pop      = !pipe_wr && !empty;

    rf_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (wb_req_t'{rd: mc_rd, data: mc_data}),
        .pop      (pop),
        .head_dat (head),
        .full     (full),
        .empty    (empty),
`ifdef RF_WB_PENDING_EN
        .slot_dat (slot_dat),
        .slot_vld (slot_vld),
`endif
        .level    (fifo_level)
    );

    always_comb begin
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (pipe_wr) begin
            wen_d   = 1'b1;
            waddr_d = pipe_rd;
            wdata_d = pipe_data;
        end else if (pop) begin
            wen_d   = 1'b1;
            waddr_d = head.rd;
            wdata_d = head.data;
        end
    end

    // Counts cycles in which a buffered result is held off by a pipeline write.
    always_comb begin
        starve_d = starve_q;
        if (empty || pop) begin
            starve_d = '0;
        end else if (pipe_wr && (starve_q != SW'(STARVE_MAX))) begin
            starve_d = starve_q + SW'(1);
        end
        stall_d = (starve_d == SW'(STARVE_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign wen       = wen_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign stall_req = stall_q;

`ifdef RF_WB_PENDING_EN
    always_comb begin
        pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (slot_vld[i]) pending[slot_dat[i].rd] = 1'b1;
        end
        pending[0] = 1'b0;
    end
`endif

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Self-checking bench for rf_wb_ctrl: vector table, directed corner sequences, random vs queue model.
// Honours RF_WB_PENDING_EN when defined.
module tb_rf_wb_ctrl;
    localparam int DEPTH = 4;
    localparam int SMAX  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        stall_req;
    logic [2:0]  fifo_level;
`ifdef RF_WB_PENDING_EN
    logic [31:0] pending;
`endif

    rf_wb_ctrl #(
        .ADDR_WIDTH (5),
        .DATAWIDTH  (32),
        .FIFO_DEPTH (DEPTH),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pipe_valid (pipe_valid),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .mc_valid   (mc_valid),
        .mc_ready   (mc_ready),
        .mc_rd      (mc_rd),
        .mc_data    (mc_data),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .stall_req  (stall_req),
`ifdef RF_WB_PENDING_EN
        .pending    (pending),
`endif
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        pv;
        logic [4:0]  prd;
        logic [31:0] pd;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        e_wen;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [2:0]  e_lvl;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: RF write port seen as a queue plus a wait counter.
    ent_t        mq[$];
    logic        m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    int          m_starve;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_wen    = 1'b0;
        m_waddr  = '0;
        m_wdata  = '0;
        m_starve = 0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".wen"},   wen,        m_wen);
        chk({tag, ".waddr"}, waddr,      m_waddr);
        chk({tag, ".wdata"}, wdata,      m_wdata);
        chk({tag, ".level"}, fifo_level, mq.size());
        chk({tag, ".ready"}, mc_ready,   mq.size() < DEPTH);
        chk({tag, ".stall"}, stall_req,  m_starve == SMAX);
`ifdef RF_WB_PENDING_EN
        begin
            logic [31:0] exp_p;
            exp_p = '0;
            foreach (mq[k]) exp_p[mq[k].rd] = 1'b1;
            exp_p[0] = 1'b0;
            chk({tag, ".pending"}, pending, exp_p);
        end
`endif
    endtask

    // Drive one cycle of inputs, advance the model, and compare after the edge.
    task automatic cycle(input string tag, input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        int   sz;
        logic pw;
        logic popped;
        ent_t e;
        pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
        mc_valid   = mv; mc_rd   = mrd; mc_data   = md;
        sz     = mq.size();
        pw     = pv && (prd != 0);
        popped = !pw && (sz > 0);
        if (pw) begin
            m_wen = 1'b1; m_waddr = prd; m_wdata = pd;
        end else if (popped) begin
            e = mq.pop_front();
            m_wen = 1'b1; m_waddr = e.rd; m_wdata = e.data;
        end else begin
            m_wen = 1'b0;
        end
        if (mv && (sz < DEPTH) && (mrd != 0)) mq.push_back('{rd: mrd, data: md});
        if (sz == 0 || popped) m_starve = 0;
        else if (m_starve < SMAX) m_starve++;
        @(posedge clk);
        #1;
        chk_model(tag);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,  1'b1, 5'd5,  32'hDEADBEEF, 3'd0};
        vecs[1] = '{1'b1, 5'd0,  32'h1234,     1'b0, 5'd0,  32'h0,  1'b0, 5'd5,  32'hDEADBEEF, 3'd0};
        vecs[2] = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd9,  32'h99, 1'b1, 5'd3,  32'h11,       3'd1};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'hAA, 1'b1, 5'd9,  32'h99,       3'd1};
        vecs[4] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b1, 5'd10, 32'hAA,       3'd0};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h77, 1'b0, 5'd10, 32'hAA,       3'd0};
        vecs[6] = '{1'b1, 5'd31, 32'h5,        1'b0, 5'd0,  32'h0,  1'b1, 5'd31, 32'h5,        3'd0};

        rst_n = 1'b0;
        pipe_valid = 0; pipe_rd = 0; pipe_data = 0;
        mc_valid = 0; mc_rd = 0; mc_data = 0;
        model_reset();
        #12;
        chk("rst.wen",   wen,        1'b0);
        chk("rst.waddr", waddr,      5'd0);
        chk("rst.wdata", wdata,      32'd0);
        chk("rst.stall", stall_req,  1'b0);
        chk("rst.level", fifo_level, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.ready", mc_ready, 1'b1);

        foreach (vecs[i]) begin
            cycle($sformatf("vec%0d", i), vecs[i].pv, vecs[i].prd, vecs[i].pd,
                  vecs[i].mv, vecs[i].mrd, vecs[i].md);
            chk($sformatf("vec%0d.wen", i),   wen,        vecs[i].e_wen);
            chk($sformatf("vec%0d.addr", i),  waddr,      vecs[i].e_addr);
            chk($sformatf("vec%0d.data", i),  wdata,      vecs[i].e_data);
            chk($sformatf("vec%0d.level", i), fifo_level, vecs[i].e_lvl);
        end

        // Fill with the pipeline busy: fifth push must be refused.
        for (int i = 1; i <= 5; i++) begin
            cycle("fill", 1'b1, 5'd31, 32'(i), 1'b1, 5'(i), 32'h100 + 32'(i));
            if (i == 3) chk("fill3.ready", mc_ready, 1'b1);
        end
        chk("fill.level", fifo_level, 3'd4);
        chk("fill.ready", mc_ready,   1'b0);

        // Idle pipeline drains 1..4 back-to-back in arrival order.
        for (int i = 1; i <= 4; i++) begin
            cycle("drain", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            chk("drain.wen",   wen,   1'b1);
            chk("drain.waddr", waddr, 5'(i));
            chk("drain.wdata", wdata, 32'h100 + 32'(i));
        end
        cycle("drain_end", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("drain_end.wen",   wen,        1'b0);
        chk("drain_end.level", fifo_level, 3'd0);

        // Starvation: one entry held off for STARVE_MAX cycles.
        cycle("starve_push", 1'b1, 5'd2, 32'h2, 1'b1, 5'd6, 32'h66);
        for (int k = 1; k <= SMAX; k++) begin
            cycle("starve", 1'b1, 5'd2, 32'(k), 1'b0, 5'd0, 32'd0);
            if (k == SMAX - 1) chk("starve7.stall", stall_req, 1'b0);
        end
        chk("starve8.stall", stall_req, 1'b1);
        cycle("starve_rel", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("starve_rel.wen",   wen,       1'b1);
        chk("starve_rel.waddr", waddr,     5'd6);
        chk("starve_rel.wdata", wdata,     32'h66);
        chk("starve_rel.stall", stall_req, 1'b0);

        // x0 result is accepted and dropped.
        cycle("x0", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h77);
        chk("x0.level", fifo_level, 3'd0);
        chk("x0.wen",   wen,        1'b0);
        cycle("pend_push", 1'b1, 5'd3, 32'h3, 1'b1, 5'd7, 32'h7);
`ifdef RF_WB_PENDING_EN
        chk("pend7.set", pending[7], 1'b1);
`endif
        cycle("pend_pop", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("pend_pop.waddr", waddr, 5'd7);
`ifdef RF_WB_PENDING_EN
        chk("pend7.clr", pending[7], 1'b0);
`endif

        // Reset asserted mid-drain clears outputs without waiting for a clock edge.
        for (int i = 0; i < 4; i++) cycle("rfill", 1'b1, 5'd1, 32'd0, 1'b1, 5'(11 + i), 32'(i));
        cycle("rdrain", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("rdrain.level", fifo_level, 3'd3);
        chk("rdrain.wen",   wen,        1'b1);
        rst_n = 1'b0;
        #1;
        chk("rmid.wen",   wen,        1'b0);
        chk("rmid.level", fifo_level, 3'd0);
        chk("rmid.stall", stall_req,  1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_model("rmid_rel");

        // Random traffic with phases of light and heavy pipeline load.
        for (int n = 0; n < 800; n++) begin
            int   pct;
            logic pv, mv;
            logic [4:0] prd, mrd;
            pct = ((n / 100) % 2 == 1) ? 95 : 40;
            pv  = ($urandom_range(0, 99) < pct);
            mv  = ($urandom_range(0, 1) == 1);
            prd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            mrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            cycle("rand", pv, prd, $urandom, mv, mrd, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
